wide_field_rmw: RTL and testbench
=================================

WIDE_FIELD_RMW -- requirements
Module: wide_field_rmw

Interface
REQ-001 Parameter WIDTH, 74, bit width of the held multi-word state.
REQ-002 Parameter FW, 32, field width of every write and read.
REQ-003 Parameter INIT, 74'h2bcf02356897801abfe, state value loaded at reset.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 wr_valid  input  1  write request present.
REQ-007 wr_ready  output  1  block accepts a write this cycle.
REQ-008 wr_off  input  7  LSB index of the target field within the state.
REQ-009 wr_data  input  FW  field value to merge.
REQ-010 rd_valid  input  1  read request; always accepted.
REQ-011 rd_off  input  7  LSB index of the field to read.
REQ-012 rd_data  output  FW  read result.
REQ-013 rd_data_valid  output  1  rd_data is valid this cycle.
REQ-014 state_o  output  WIDTH  committed state.
REQ-015 err_o  output  1  one-cycle pulse on an out-of-range request.
REQ-016 wr_count  output  16  number of committed writes, wrapping.

Function
REQ-017 A write SHALL be accepted on a rising edge where wr_valid && wr_ready.
REQ-018 Accepted write SHALL be held in a pending stage (off, data) for one cycle.
- The merge into state SHALL occur on the next edge.
- The merged value SHALL appear on state_o one cycle after acceptance.
REQ-019 Merge rule: state[wr_off +: FW] = wr_data, other bits unchanged.
- Field bits at index >= WIDTH SHALL be discarded.
REQ-020 wr_off >= WIDTH SHALL drop the write, pulse err_o for one cycle, and leave state and wr_count unchanged.
REQ-021 wr_ready SHALL be 0 during reset and the first cycle after reset deasserts, then 1 constantly.
- Back-to-back writes SHALL be sustained at one per cycle.
REQ-022 Consecutive writes to overlapping fields SHALL commit in acceptance order; the later write wins on overlapping bits.
REQ-023 Read latency SHALL be 1 cycle.
- rd_data_valid is high the cycle after rd_valid.
- rd_data is zero-extended: state bits at index >= WIDTH read as 0.
- rd_off >= WIDTH returns 0 and pulses err_o.
REQ-024 Read data source: the state as it stands after all writes accepted in earlier cycles.
- When the pending stage holds a write, read data SHALL be forwarded from it (no stale read).
REQ-025 A read and a write accepted in the same cycle: the read SHALL return the value excluding that write.
REQ-026 wr_count SHALL increment by 1 per committed write, wrapping 16'hFFFF -> 0.
REQ-027 err_o for a read and a write in the same cycle SHALL be a single OR'd pulse.

Reset
REQ-028 While rst_n = 0 at an edge, the following SHALL hold:
- state_o = INIT
- pending stage empty
- rd_data = 0, rd_data_valid = 0, err_o = 0, wr_count = 0, wr_ready = 0
REQ-029 Reset asserted with a write pending SHALL discard that write; no partial merge.

Structure
REQ-030 A shared package wide_rmw_pkg SHALL hold:
- OFF_W = 7
- a pending-write struct {valid, off, data}
- a merge function (state, off, data) -> state, used by both the commit path and the forward path.
REQ-031 One sub-module field_extract SHALL perform the combinational variable-offset slice for the read path.

Verification
REQ-032 Reset then idle 4 cycles -> state_o = 74'h2bcf02356897801abfe, wr_count = 0, wr_ready = 1 from the 2nd post-reset cycle.
REQ-033 Write off=15, data=32'h897abc16 -> one cycle later state_o = 74'h2bcf02344bd5e0b2bfe, wr_count = 1.
REQ-034 Back-to-back writes off=15, data=32'h897abc16 then 32'h897abc17 -> final state_o = 74'h2bcf02344bd5e0babfe, wr_count = 2.
REQ-035 Write off=15, data=32'h897abc16, with read off=15 on the next cycle (forward path) -> rd_data = 32'h897abc16, rd_data_valid = 1.
REQ-036 Write off=60, data=32'hffffffff -> state bits [73:60] all 1, lower bits unchanged; read off=60 -> rd_data = 32'h00003fff.
REQ-037 Write off=80 -> err_o pulses once, state and wr_count unchanged; rst_n low with a write pending -> state_o = INIT.

Source files
------------

// File: rtl/wide_rmw_pkg.sv
// Shared types and the field-merge helper for the wide field read-modify-write block.
package wide_rmw_pkg;

  localparam int unsigned OFF_W   = 7;
  localparam int unsigned STATE_W = 74;
  localparam int unsigned FIELD_W = 32;
  localparam int unsigned CNT_W   = 16;

  typedef struct packed {
    logic               valid;
    logic [OFF_W-1:0]   off;
    logic [FIELD_W-1:0] data;
  } pend_t;

  // Overwrite state[off +: FIELD_W] with data; field bits past the top of state fall off.
  function automatic logic [STATE_W-1:0] merge_field(
    input logic [STATE_W-1:0] state,
    input logic [OFF_W-1:0]   off,
    input logic [FIELD_W-1:0] data
  );
    logic [STATE_W-1:0] mask;
    logic [STATE_W-1:0] ins;
    mask = STATE_W'({FIELD_W{1'b1}}) << off;
    ins  = STATE_W'(data) << off;
    return (state & ~mask) | ins;
  endfunction

endpackage

// File: rtl/field_extract.sv
// Combinational variable-offset field slice; bits beyond the state read as zero.
module field_extract
  import wide_rmw_pkg::*;
#(
  parameter int unsigned WIDTH = STATE_W,
  parameter int unsigned FW    = FIELD_W
) (
  input  logic [WIDTH-1:0] state,
  input  logic [OFF_W-1:0] off,
  output logic [FW-1:0]    field_c
);

  always_comb begin
    field_c = FW'(state >> off);
  end

endmodule

// File: rtl/wide_field_rmw.sv
// Wide state register updated by field writes through a one-entry pending stage,
// with forwarded single-cycle field reads.
module wide_field_rmw
  import wide_rmw_pkg::*;
#(
  parameter int unsigned     WIDTH = STATE_W,
  parameter int unsigned     FW    = FIELD_W,
  parameter logic [WIDTH-1:0] INIT = 74'h2bcf02356897801abfe
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [FW-1:0]    wr_data,
  input  logic             rd_valid,
  input  logic [OFF_W-1:0] rd_off,
  output logic [FW-1:0]    rd_data,
  output logic             rd_data_valid,
  output logic [WIDTH-1:0] state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] wr_count
);

  logic [WIDTH-1:0] state_q;
  pend_t            pend_q;
  logic             wr_ready_q;
  logic [FW-1:0]    rd_data_q;
  logic             rd_data_valid_q;
  logic             err_q;
  logic [CNT_W-1:0] wr_count_q;

  logic             wr_fire;
  logic             wr_bad;
  logic             rd_bad;
  logic [WIDTH-1:0] view;
  logic [FW-1:0]    rd_field;

  // The view is the state after every earlier-accepted write; it is also the next state.
  always_comb begin
    wr_fire = wr_valid && wr_ready_q;
    wr_bad  = wr_fire && (wr_off >= OFF_W'(WIDTH));
    rd_bad  = rd_valid && (rd_off >= OFF_W'(WIDTH));
    view    = pend_q.valid ? merge_field(state_q, pend_q.off, pend_q.data) : state_q;
  end

  field_extract #(
    .WIDTH (WIDTH),
    .FW    (FW)
  ) u_extract (
    .state   (view),
    .off     (rd_off),
    .field_c (rd_field)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= INIT;
      pend_q          <= '0;
      wr_ready_q      <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      err_q           <= 1'b0;
      wr_count_q      <= '0;
    end else begin
      wr_ready_q      <= 1'b1;
      state_q         <= view;
      if (pend_q.valid) begin
        wr_count_q <= wr_count_q + CNT_W'(1);
      end
      pend_q.valid    <= wr_fire && !wr_bad;
      pend_q.off      <= wr_off;
      pend_q.data     <= wr_data;
      rd_data_valid_q <= rd_valid;
      rd_data_q       <= (rd_valid && !rd_bad) ? rd_field : '0;
      err_q           <= wr_bad || rd_bad;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign state_o       = state_q;
  assign err_o         = err_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_wide_field_rmw.sv
// Directed self-checking bench for wide_field_rmw.
module tb_wide_field_rmw;

  localparam logic [73:0] INIT_V = 74'h2bcf02356897801abfe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_off;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [6:0]  rd_off;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic [73:0] state_o;
  logic        err_o;
  logic [15:0] wr_count;

  int vectors = 0;
  int errors  = 0;

  wide_field_rmw dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_off        (wr_off),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_off        (rd_off),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .state_o       (state_o),
    .err_o         (err_o),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    wr_off   = '0;
    wr_data  = '0;
    rd_valid = 1'b0;
    rd_off   = '0;
  endtask

  // Reset, then one cycle so wr_ready is up.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if (state_o !== INIT_V || wr_count !== 16'd0 || wr_ready !== 1'b0 ||
        rd_data_valid !== 1'b0 || rd_data !== 32'd0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: state=%h cnt=%h rdy=%b rdv=%b rd=%h err=%b",
               state_o, wr_count, wr_ready, rd_data_valid, rd_data, err_o);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_first_cycle: got %b want 0", wr_ready);
    end
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (state_o !== INIT_V || wr_count !== 16'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: state=%h cnt=%h rdy=%b", state_o, wr_count, wr_ready);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    wr_valid = 1'b1; wr_off = 7'd15; wr_data = 32'h897abc16;
    step();
    wr_valid = 1'b0;
    vectors++;
    if (state_o !== INIT_V) begin
      errors++;
      $display("FAIL write_pending_state: got %h want %h", state_o, INIT_V);
    end
    step();
    vectors++;
    if (state_o !== 74'h2bcf02344bd5e0b2bfe || wr_count !== 16'd1) begin
      errors++;
      $display("FAIL single_write: state=%h cnt=%0d want 2bcf02344bd5e0b2bfe cnt=1",
               state_o, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_valid = 1'b1; wr_off = 7'd15; wr_data = 32'h897abc16;
    step();
    wr_data = 32'h897abc17;
    step();
    wr_valid = 1'b0;
    step();
    vectors++;
    if (state_o !== 74'h2bcf02344bd5e0babfe || wr_count !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back: state=%h cnt=%0d want 2bcf02344bd5e0babfe cnt=2",
               state_o, wr_count);
    end
  endtask

  task automatic test_forward();
    do_reset();
    wr_valid = 1'b1; wr_off = 7'd15; wr_data = 32'h897abc16;
    step();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_off = 7'd15;
    step();
    rd_valid = 1'b0;
    vectors++;
    if (rd_data !== 32'h897abc16 || rd_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL forward_read: rd=%h v=%b want 897abc16 v=1", rd_data, rd_data_valid);
    end
    step();
    vectors++;
    if (rd_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_drop: got %b want 0", rd_data_valid);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr_valid = 1'b1; wr_off = 7'd15; wr_data = 32'h897abc16;
    rd_valid = 1'b1; rd_off = 7'd15;
    step();
    idle_inputs();
    vectors++;
    if (rd_data !== 32'had12f003 || rd_data_valid !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_read: rd=%h v=%b err=%b want ad12f003 v=1 err=0",
               rd_data, rd_data_valid, err_o);
    end
  endtask

  task automatic test_top_field();
    do_reset();
    rd_valid = 1'b1; rd_off = 7'd70;
    step();
    rd_valid = 1'b0;
    vectors++;
    if (rd_data !== 32'h0000000a || err_o !== 1'b0) begin
      errors++;
      $display("FAIL read_off70: rd=%h err=%b want 0000000a err=0", rd_data, err_o);
    end
    wr_valid = 1'b1; wr_off = 7'd60; wr_data = 32'hffffffff;
    step();
    wr_valid = 1'b0;
    step();
    vectors++;
    if (state_o !== 74'h3fff02356897801abfe || wr_count !== 16'd1) begin
      errors++;
      $display("FAIL write_off60: state=%h cnt=%0d want 3fff02356897801abfe cnt=1",
               state_o, wr_count);
    end
    rd_valid = 1'b1; rd_off = 7'd60;
    step();
    rd_valid = 1'b0;
    vectors++;
    if (rd_data !== 32'h00003fff || rd_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_off60: rd=%h v=%b want 00003fff v=1", rd_data, rd_data_valid);
    end
  endtask

  task automatic test_errors();
    do_reset();
    wr_valid = 1'b1; wr_off = 7'd80; wr_data = 32'h12345678;
    step();
    wr_valid = 1'b0;
    vectors++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_wr_pulse: got %b want 1", err_o);
    end
    step();
    vectors++;
    if (err_o !== 1'b0 || state_o !== INIT_V || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL err_wr_dropped: err=%b state=%h cnt=%0d", err_o, state_o, wr_count);
    end
    rd_valid = 1'b1; rd_off = 7'd100;
    step();
    rd_valid = 1'b0;
    vectors++;
    if (err_o !== 1'b1 || rd_data !== 32'd0 || rd_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL err_rd: err=%b rd=%h v=%b want 1 0 1", err_o, rd_data, rd_data_valid);
    end
    wr_valid = 1'b1; wr_off = 7'd127; wr_data = 32'hdeadbeef;
    rd_valid = 1'b1; rd_off = 7'd74;
    step();
    idle_inputs();
    vectors++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_both: got %b want 1", err_o);
    end
    step();
    vectors++;
    if (err_o !== 1'b0 || state_o !== INIT_V || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL err_both_after: err=%b state=%h cnt=%0d", err_o, state_o, wr_count);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    wr_valid = 1'b1; wr_off = 7'd15; wr_data = 32'h897abc16;
    step();
    wr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    vectors++;
    if (state_o !== INIT_V || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_pending: state=%h cnt=%0d want INIT cnt=0", state_o, wr_count);
    end
    rst_n = 1'b1;
    step();
    step();
    vectors++;
    if (state_o !== INIT_V || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_pending_after: state=%h cnt=%0d", state_o, wr_count);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_forward();
    test_same_cycle();
    test_top_field();
    test_errors();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
